// File: rtl/mmio_slot_initiator.sv
// mmio_slot_initiator: turns one upstream request at a time into a slot
// bus transaction (IDLE -> ISSUE -> COMPLETE -> RESP) and holds the captured
// response until the upstream side consumes it.
// Optional ISSUE watchdog: define MMIO_SLOT_INITIATOR_TIMEOUT_EN.
module mmio_slot_initiator #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_slave_error,
  output logic        rsp_decode_error,
  output logic        rsp_timeout,
  output logic        chip_select,
  output logic        read,
  output logic        write,
  output logic [7:0]  addr,
  output logic [31:0] wr_data,
  output logic        transaction_completed,
  input  logic [31:0] rd_data,
  input  logic        rd_done,
  input  logic        wr_done,
  input  logic        slave_error,
  input  logic        decode_error,
  input  logic        idle
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COMPLETE, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_write;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_slv_err;
  logic        r_dec_err;
  logic        r_timeout;
  logic        w_accept;
  logic        w_done;
  logic        w_timeout_hit;
  logic        w_unused;

  // idle is informational only; the FSM never looks at it.
  assign w_unused = ^{idle, TIMEOUT_WIDTH'(TIMEOUT_CYCLES)};

  assign w_accept = (r_state == S_IDLE) && req_valid;
  // Only the done pulse matching the registered direction counts, and only in ISSUE.
  assign w_done   = (r_state == S_ISSUE) && (r_write ? wr_done : rd_done);

`ifdef MMIO_SLOT_INITIATOR_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] r_tmo_cnt;

  // Watchdog: cleared when a request is accepted, counts every ISSUE cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)
      r_tmo_cnt <= '0;
    else if (w_accept)
      r_tmo_cnt <= '0;
    else if (r_state == S_ISSUE)
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  // Fires in the TIMEOUT_CYCLES-th ISSUE cycle; a done in that same cycle wins.
  assign w_timeout_hit = (r_state == S_ISSUE) && !w_done &&
                         (r_tmo_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  // Next state and state-decoded strobes (all from registers only).
  always_comb begin
    w_state_next          = r_state;
    req_ready             = 1'b0;
    chip_select           = 1'b0;
    read                  = 1'b0;
    write                 = 1'b0;
    transaction_completed = 1'b0;
    rsp_valid             = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        chip_select = 1'b1;
        read        = ~r_write;
        write       = r_write;
        if (w_done || w_timeout_hit) w_state_next = S_COMPLETE;
      end
      S_COMPLETE: begin
        transaction_completed = 1'b1;
        w_state_next          = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request capture on accept; response capture on done or watchdog abort.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_slv_err <= 1'b0;
      r_dec_err <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_done) begin
        r_rdata   <= r_write ? 32'h0 : rd_data;
        r_slv_err <= slave_error;
        r_dec_err <= decode_error;
        r_timeout <= 1'b0;
      end else if (w_timeout_hit) begin
        r_rdata   <= 32'h0;
        r_slv_err <= 1'b0;
        r_dec_err <= 1'b0;
        r_timeout <= 1'b1;
      end
    end
  end

  assign addr             = r_addr;
  assign wr_data          = r_wdata;
  assign rsp_rdata        = r_rdata;
  assign rsp_slave_error  = r_slv_err;
  assign rsp_decode_error = r_dec_err;
  assign rsp_timeout      = r_timeout;

endmodule

// File: tb/tb_mmio_slot_initiator.sv
// Directed bench for mmio_slot_initiator with a small uart-like slot model.
// Build with MMIO_SLOT_INITIATOR_TIMEOUT_EN defined to exercise the watchdog.
module tb_mmio_slot_initiator;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slave_error, rsp_decode_error, rsp_timeout;
  logic        chip_select, read, write;
  logic [7:0]  addr;
  logic [31:0] wr_data;
  logic        transaction_completed;
  logic [31:0] rd_data;
  logic        rd_done, wr_done, slave_error, decode_error, idle;

  int checks = 0;
  int errors = 0;
  int tc_count = 0;

  // Slot model knobs
  logic       alive = 1'b1;
  logic       wrong_en = 1'b0;
  logic       stray = 1'b0;
  int         done_at = 2;
  logic [3:0] r_cnt = '0;
  logic       w_hit;

`ifdef MMIO_SLOT_INITIATOR_TIMEOUT_EN
  localparam int TCYC = 4;
`else
  localparam int TCYC = 255;
`endif

  mmio_slot_initiator #(.TIMEOUT_CYCLES(TCYC)) dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slave_error(rsp_slave_error), .rsp_decode_error(rsp_decode_error),
    .rsp_timeout(rsp_timeout),
    .chip_select(chip_select), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data),
    .transaction_completed(transaction_completed),
    .rd_data(rd_data), .rd_done(rd_done), .wr_done(wr_done),
    .slave_error(slave_error), .decode_error(decode_error), .idle(idle)
  );

  always #5 clk = ~clk;

  // Slot responder: counts chip_select cycles, completes at ISSUE cycle done_at.
  always @(posedge clk) begin
    if (!chip_select) r_cnt <= '0;
    else if (r_cnt != 4'hF) r_cnt <= r_cnt + 4'd1;
  end

  assign w_hit = chip_select && alive && (int'(r_cnt) >= done_at);
  assign rd_done = (w_hit & read) | (chip_select & write & wrong_en & (r_cnt == 4'd0)) | stray;
  assign wr_done = (w_hit & write) | (chip_select & read & wrong_en & (r_cnt == 4'd0)) | stray;
  // Outside the done cycle the data/error lines carry junk that must be ignored.
  assign rd_data = w_hit ? ((addr == 8'h08) ? 32'h0000_0145 :
                            (addr == 8'h10) ? 32'h0000_0100 : 32'h0) : 32'hDEAD_BEEF;
  assign slave_error  = w_hit ? ((addr == 8'h00) && read) : 1'b1;
  assign decode_error = w_hit ? !((addr == 8'h00) || (addr == 8'h04) ||
                                  (addr == 8'h08) || (addr == 8'h10)) : 1'b1;

  // Count completion pulses.
  always @(negedge clk) if (transaction_completed) tc_count <= tc_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request at a negedge and let it be accepted on the next posedge.
  task automatic start_req(input string tag, input logic wr, input logic [7:0] a,
                           input logic [31:0] wd);
    @(negedge clk);
    check({tag, ":req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    // Scramble the request bus: slot outputs must keep the registered values.
    req_valid = 1'b0; req_write = ~wr; req_addr = 8'hFF; req_wdata = 32'h0BAD_0BAD;
    check({tag, ":issue_strobes"}, {29'd0, chip_select, read, write}, {29'd0, 1'b1, ~wr, wr});
    check({tag, ":issue_addr"}, 32'(addr), 32'(a));
    check({tag, ":issue_wdata"}, wr_data, wd);
    check({tag, ":req_ready_busy"}, 32'(req_ready), 32'd0);
  endtask

  task automatic run_txn(input string tag, input logic wr, input logic [7:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_se, input logic exp_de, input logic exp_to,
                         input int exp_k, input int hold);
    int k;
    int tc0;
    tc0 = tc_count;
    start_req(tag, wr, a, wd);
    k = 0;
    while (!transaction_completed && k < 60) begin
      @(negedge clk);
      k++;
    end
    check({tag, ":tc_cycle"}, 32'(k), 32'(exp_k));
    check({tag, ":complete_strobes"}, {29'd0, chip_select, read, write}, 32'd0);
    @(negedge clk);
    check({tag, ":tc_once"}, 32'(tc_count - tc0), 32'd1);
    check({tag, ":rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ":rdata"}, rsp_rdata, exp_rd);
    check({tag, ":errs_to"}, {29'd0, rsp_slave_error, rsp_decode_error, rsp_timeout},
          {29'd0, exp_se, exp_de, exp_to});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ":hold_rsp"}, {rsp_rdata[28:0], rsp_valid, rsp_slave_error, rsp_decode_error},
            {exp_rd[28:0], 1'b1, exp_se, exp_de});
      check({tag, ":hold_quiet"}, {28'd0, req_ready, chip_select, read, write}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ":after_hs"}, {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    int tc0;
    arst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0; idle = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outs", {24'd0, rsp_valid, rsp_slave_error, rsp_decode_error, rsp_timeout,
                         chip_select, read, write, transaction_completed}, 32'd0);
    check("reset_bus", {addr, wr_data[23:0]} | rsp_rdata, 32'd0);
    arst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd1);

    // uart dvsr read, write to TX, decode error, RX empty, status
    run_txn("rd_dvsr", 1'b0, 8'h08, 32'h0, 32'h0000_0145, 1'b0, 1'b0, 1'b0, 3, 0);
    run_txn("wr_tx",   1'b1, 8'h04, 32'h41, 32'h0, 1'b0, 1'b0, 1'b0, 3, 0);
    run_txn("rd_dec",  1'b0, 8'h20, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 3, 0);
    run_txn("rd_rxe",  1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 3, 0);
    run_txn("rd_stat", 1'b0, 8'h10, 32'h0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 3, 10);

    // Wrong-type done pulses in ISSUE cycle 0 are ignored
    wrong_en = 1'b1;
    run_txn("wrong_rd", 1'b0, 8'h08, 32'h0, 32'h0000_0145, 1'b0, 1'b0, 1'b0, 3, 0);
    run_txn("wrong_wr", 1'b1, 8'h04, 32'h5A, 32'h0, 1'b0, 1'b0, 1'b0, 3, 0);
    wrong_en = 1'b0;

    // Done pulses while IDLE are ignored
    tc0 = tc_count;
    @(negedge clk); stray = 1'b1;
    @(negedge clk); stray = 1'b0;
    check("stray_idle", {29'd0, req_ready, chip_select, rsp_valid}, 32'd4);
    @(negedge clk);
    check("stray_no_tc", 32'(tc_count - tc0), 32'd0);

    // Done arriving in the 4th ISSUE cycle (coincides with watchdog when enabled)
    done_at = 3;
    run_txn("late_done", 1'b0, 8'h08, 32'h0, 32'h0000_0145, 1'b0, 1'b0, 1'b0, 4, 0);
    done_at = 2;

`ifdef MMIO_SLOT_INITIATOR_TIMEOUT_EN
    alive = 1'b0;
    run_txn("timeout", 1'b0, 8'h08, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4, 0);
    alive = 1'b1;
`else
    // No watchdog: a dead slot keeps ISSUE open
    alive = 1'b0;
    tc0 = tc_count;
    start_req("nowd", 1'b0, 8'h08, 32'h0);
    repeat (20) @(negedge clk);
    check("nowd_still_issue", {30'd0, chip_select, read}, 32'd3);
    check("nowd_no_tc", 32'(tc_count - tc0), 32'd0);
    alive = 1'b1;
    @(negedge clk);
    check("nowd_tc", 32'(transaction_completed), 32'd1);
    @(negedge clk);
    check("nowd_rsp", {rsp_rdata[30:0], rsp_timeout}, {31'h145, 1'b0});
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
`endif

    // Reset during ISSUE: strobes drop, no completion pulse
    alive = 1'b0;
    tc0 = tc_count;
    start_req("rst_issue", 1'b1, 8'h04, 32'h77);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    check("rst_issue_strobes", {28'd0, chip_select, read, write, transaction_completed}, 32'd0);
    check("rst_issue_addr", 32'(addr), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    alive = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_issue_no_tc", 32'(tc_count - tc0), 32'd0);
    check("rst_issue_ready", 32'(req_ready), 32'd1);

    // Reset during RESP: rsp_valid drops
    start_req("rst_resp", 1'b0, 8'h08, 32'h0);
    repeat (4) @(negedge clk);
    check("rst_resp_pre", {rsp_valid, rsp_rdata[30:0]}, {1'b1, 31'h145});
    arst_n = 1'b0;
    #1;
    check("rst_resp_post", {rsp_valid, rsp_rdata[30:0]}, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    check("rst_resp_ready", 32'(req_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/mmio_slot_initiator.md
MMIO_SLOT_INITIATOR -- requirements
Module: mmio_slot_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles spent in ISSUE before abort.
REQ-002 SHALL have parameter TIMEOUT_WIDTH, default $clog2(TIMEOUT_CYCLES+1): timeout counter width.
REQ-003 SHALL have ports, in this order:
- clk  in  1  clock
- arst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  upstream request present
- req_ready  out  1  request accepted this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  8  slot register address
- req_wdata  in  32  write data
- rsp_valid  out  1  response held
- rsp_ready  in  1  upstream consumes response
- rsp_rdata  out  32  captured read data; 0 for writes and timeouts
- rsp_slave_error  out  1  captured slave_error
- rsp_decode_error  out  1  captured decode_error
- rsp_timeout  out  1  transaction aborted by watchdog
- chip_select, read, write  out  1 each  slot strobes
- addr  out  8  slot address
- wr_data  out  32  slot write data
- transaction_completed  out  1  slot release pulse
- rd_data  in  32  slot read data
- rd_done, wr_done  in  1 each  slot completion pulses, one cycle wide
- slave_error, decode_error  in  1 each  slot error flags
- idle  in  1  slot idle indication; informational, unused by the FSM

Function
REQ-004 SHALL implement FSM states IDLE, ISSUE, COMPLETE, RESP.
REQ-005 req_ready SHALL be 1 only in IDLE; req_valid && req_ready SHALL register req_write, req_addr and req_wdata and move the FSM to ISSUE.
REQ-006 In ISSUE, chip_select SHALL be 1, read SHALL be ~write_q, write SHALL be write_q, and addr and wr_data SHALL hold the registered request, stable until ISSUE exits.
REQ-007 In ISSUE, rd_done (read) or wr_done (write) SHALL capture rd_data (reads only, else 0), slave_error and decode_error, then move to COMPLETE.
REQ-008 A done pulse of the wrong type, or any done pulse outside ISSUE, SHALL be ignored.
REQ-009 slave_error and decode_error SHALL be sampled only in the accepted done cycle; their values at any other time SHALL be ignored.
REQ-010 COMPLETE SHALL last exactly one cycle, with transaction_completed=1, chip_select=read=write=0, then move to RESP.
REQ-011 RESP SHALL hold rsp_valid=1 and all rsp_* fields constant until rsp_ready=1, then return to IDLE.
REQ-012 All slot outputs SHALL be driven from state and request registers only, with no combinational path from slot inputs.
REQ-013 With a one-cycle-ACTIVE responder, done SHALL arrive in the 3rd ISSUE cycle: accept at cycle 0, transaction_completed at cycle 3, rsp_valid from cycle 4.
REQ-014 A new request SHALL be accepted in the cycle immediately after an RESP handshake; no back-to-back acceptance SHALL occur without returning to IDLE.

Reset
REQ-015 On arst_n=0, the FSM SHALL go to IDLE immediately; all outputs except req_ready SHALL be 0, and req_ready SHALL be 1 after release.
REQ-016 Reset during ISSUE or RESP SHALL drop chip_select, read, write and rsp_valid without producing a transaction_completed pulse.

Configuration
REQ-017 Macro MMIO_SLOT_INITIATOR_TIMEOUT_EN SHALL control the ISSUE watchdog.
REQ-018 With the macro defined, a counter SHALL clear on entry to ISSUE and increment each ISSUE cycle. Reaching TIMEOUT_CYCLES without done SHALL set rsp_timeout=1, rsp_rdata=0 and both error fields 0, then go to COMPLETE. Done and timeout in the same cycle SHALL resolve as done.
REQ-019 Without the macro, no counter SHALL exist, rsp_timeout SHALL be tied to 0, and ISSUE SHALL wait indefinitely.

Verification
REQ-020 Read of 0x08 from a uart with dvsr=0x145 -> transaction_completed at cycle 3; rsp_rdata=0x00000145; both errors 0.
REQ-021 Write 0x41 to 0x04 with the TX FIFO not full -> wr_done accepted, rsp_slave_error=0, rsp_rdata=0.
REQ-022 Read of 0x20 -> rsp_decode_error=1, rsp_slave_error=0.
REQ-023 Read of 0x00 with the RX FIFO empty -> rsp_slave_error=1; a following read of 0x10 returns bit8=1.
REQ-024 rsp_ready held 0 for 10 cycles -> rsp fields stable, req_ready=0, no slot strobes.
REQ-025 With the macro defined, TIMEOUT_CYCLES=4 and a dead slot -> rsp_timeout=1 after 4 ISSUE cycles; transaction_completed pulses once.
